// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: sequences one data-memory access per instruction through
// IDLE/BUSY/DONE, stalls upstream while it runs, and owns the MEM/WB register.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        Branch,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] ALUResult,
  input  logic        zero,
  input  logic [31:0] WriteData,
  input  logic [4:0]  RegWriteAdd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic        RegWrite_WB,
  output logic        MemtoReg_WB,
  output logic [31:0] ReadData_WB,
  output logic [31:0] ALUResult_WB,
  output logic [4:0]  RegWriteAdd_WB,
  output logic        mem_fault
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  toCnt;
  logic [31:0] rdataQ;
  logic        faultQ;
  logic        memOp;
  logic        illegal;
  logic        retireFault;

  assign memOp       = MemRead | MemWrite;
  assign illegal     = (ALUResult[1:0] != 2'b00) | (MemRead & MemWrite);
  assign stall       = memOp & (state != DONE);
  assign retireFault = (state == DONE) & faultQ;

  // Bus outputs decode registered state only; addr/wdata are stable because
  // the upstream register is frozen by stall for the whole access.
  assign dmem_req     = (state == BUSY);
  assign dmem_we      = dmem_req & MemWrite;
  assign dmem_addr    = ALUResult;
  assign dmem_wdata   = WriteData;

  assign PCSrc        = Branch & zero & ~stall;
  assign BranchTarget = address;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      toCnt     <= '0;
      rdataQ    <= '0;
      faultQ    <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: if (memOp) begin
          if (illegal) begin
            state     <= DONE;
            faultQ    <= 1'b1;
            mem_fault <= 1'b1;
          end else begin
            state  <= BUSY;
            toCnt  <= '0;
            faultQ <= 1'b0;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            rdataQ <= dmem_rdata;
            state  <= DONE;
          end else if (toCnt == TO_LAST) begin
            // this edge closes the TIMEOUT_CYCLES-th BUSY cycle
            state     <= DONE;
            faultQ    <= 1'b1;
            mem_fault <= 1'b1;
          end else begin
            toCnt <= toCnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite_WB    <= 1'b0;
      MemtoReg_WB    <= 1'b0;
      ReadData_WB    <= '0;
      ALUResult_WB   <= '0;
      RegWriteAdd_WB <= '0;
    end else if (stall) begin
      RegWrite_WB <= 1'b0;
      MemtoReg_WB <= 1'b0;
    end else begin
      RegWrite_WB    <= RegWrite & ~retireFault;
      MemtoReg_WB    <= MemtoReg;
      ALUResult_WB   <= ALUResult;
      RegWriteAdd_WB <= RegWriteAdd;
      ReadData_WB    <= ((state == DONE) && !faultQ) ? rdataQ : '0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl; expectations come from a per-instruction
// transaction model (stall length, request count, retired MEM/WB values).
module tb_mem_stage_ctrl;
  localparam int TO = 4;

  logic        clk = 0;
  logic        rst;
  logic        RegWrite, MemtoReg, Branch, MemRead, MemWrite, zero;
  logic [31:0] address, ALUResult, WriteData;
  logic [4:0]  RegWriteAdd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, PCSrc;
  logic [31:0] BranchTarget;
  logic        RegWrite_WB, MemtoReg_WB, mem_fault;
  logic [31:0] ReadData_WB, ALUResult_WB;
  logic [4:0]  RegWriteAdd_WB;

  int nVec = 0;
  int nErr = 0;
  logic modelFault = 0;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .ALUResult(ALUResult), .zero(zero),
    .WriteData(WriteData), .RegWriteAdd(RegWriteAdd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
    .ReadData_WB(ReadData_WB), .ALUResult_WB(ALUResult_WB),
    .RegWriteAdd_WB(RegWriteAdd_WB), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task clearInputs;
    RegWrite = 0; MemtoReg = 0; Branch = 0; MemRead = 0; MemWrite = 0; zero = 0;
    address = 0; ALUResult = 0; WriteData = 0; RegWriteAdd = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Presents one instruction (caller is at posedge+1) and follows it to retirement.
  // ackDelay = number of request cycles before the ack; >= TO means never acked.
  task runInstr(input logic rw, mtr, br, z, mr, mw,
                input logic [31:0] ad, alu, wd, input logic [4:0] ra,
                input logic [31:0] rdata, input int ackDelay, input string name);
    logic memOp, illegal, tmo, faulted, st, done;
    int expStall, expReq, nReq;
    logic [31:0] expRd;
    RegWrite = rw; MemtoReg = mtr; Branch = br; zero = z; MemRead = mr; MemWrite = mw;
    address = ad; ALUResult = alu; WriteData = wd; RegWriteAdd = ra;
    memOp    = mr | mw;
    illegal  = memOp && ((alu[1:0] != 2'b00) || (mr && mw));
    tmo      = memOp && !illegal && (ackDelay >= TO);
    faulted  = illegal || tmo;
    expStall = !memOp ? 0 : illegal ? 1 : tmo ? TO + 1 : ackDelay + 2;
    expReq   = (!memOp || illegal) ? 0 : tmo ? TO : ackDelay + 1;
    expRd    = (!memOp || faulted || mw) ? 32'h0 : rdata;
    nReq = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      st = stall;
      if (dmem_req) begin
        nVec++;
        if (dmem_addr !== alu || dmem_wdata !== wd || dmem_we !== mw) begin
          nErr++;
          $display("FAIL %s bus: addr=%h wdata=%h we=%b want addr=%h wdata=%h we=%b",
                   name, dmem_addr, dmem_wdata, dmem_we, alu, wd, mw);
        end
        dmem_ack   = (nReq == ackDelay);
        dmem_rdata = mw ? 32'h0 : rdata;
        nReq++;
      end else begin
        // stray acks outside an access must be ignored
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
      end
      nVec++;
      if (st !== (i < expStall) || PCSrc !== (br & z & (i >= expStall)) || BranchTarget !== ad) begin
        nErr++;
        $display("FAIL %s cycle%0d: stall=%b PCSrc=%b tgt=%h want stall=%b PCSrc=%b tgt=%h",
                 name, i, st, PCSrc, BranchTarget, (i < expStall), br & z & (i >= expStall), ad);
      end
      if (i >= 1 && st) begin
        nVec++;
        if (RegWrite_WB !== 1'b0 || MemtoReg_WB !== 1'b0) begin
          nErr++;
          $display("FAIL %s bubble: RegWrite_WB=%b MemtoReg_WB=%b want 0 0", name, RegWrite_WB, MemtoReg_WB);
        end
      end
      @(posedge clk); #1;
      dmem_ack = 0;
      if (st === 1'b0) done = 1;
    end
    nVec++;
    if (!done) begin
      nErr++;
      $display("FAIL %s timeout: stall never dropped, got %0d want %0d stall cycles", name, 40, expStall);
    end
    if (faulted) modelFault = 1;
    nVec++;
    if (nReq != expReq) begin
      nErr++;
      $display("FAIL %s reqcount: got %0d want %0d", name, nReq, expReq);
    end
    nVec++;
    if (RegWrite_WB !== (rw & ~faulted) || MemtoReg_WB !== mtr || ALUResult_WB !== alu ||
        RegWriteAdd_WB !== ra || ReadData_WB !== expRd || mem_fault !== modelFault) begin
      nErr++;
      $display("FAIL %s wb: rw=%b mtr=%b alu=%h ra=%0d rd=%h flt=%b want rw=%b mtr=%b alu=%h ra=%0d rd=%h flt=%b",
               name, RegWrite_WB, MemtoReg_WB, ALUResult_WB, RegWriteAdd_WB, ReadData_WB, mem_fault,
               rw & ~faulted, mtr, alu, ra, expRd, modelFault);
    end
  endtask

  task test_reset;
    clearInputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    nVec++;
    if ({dmem_req, stall, RegWrite_WB, MemtoReg_WB, mem_fault} !== 5'b0 ||
        ReadData_WB !== 0 || ALUResult_WB !== 0 || RegWriteAdd_WB !== 0) begin
      nErr++;
      $display("FAIL reset: req=%b stall=%b rw=%b mtr=%b flt=%b rd=%h alu=%h ra=%0d want all 0",
               dmem_req, stall, RegWrite_WB, MemtoReg_WB, mem_fault, ReadData_WB, ALUResult_WB, RegWriteAdd_WB);
    end
    modelFault = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task test_load;
    runInstr(1, 1, 0, 0, 1, 0, 32'h0, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, "load");
  endtask

  task test_store;
    runInstr(0, 0, 0, 0, 0, 1, 32'h0, 32'h40, 32'h12345678, 5'd0, 32'h0, 3, "store");
  endtask

  task test_misaligned;
    runInstr(1, 1, 0, 0, 1, 0, 32'h0, 32'h102, 32'h0, 5'd7, 32'h0, 0, "misaligned");
  endtask

  task test_timeout;
    runInstr(1, 1, 0, 0, 1, 0, 32'h0, 32'h200, 32'h0, 5'd9, 32'hCAFEF00D, 99, "timeout");
  endtask

  task test_branch;
    runInstr(0, 0, 1, 1, 0, 0, 32'h200, 32'h8, 32'h0, 5'd0, 32'h0, 0, "branch");
  endtask

  task test_back_to_back;
    runInstr(1, 1, 0, 0, 1, 0, 32'h0, 32'h10, 32'h0, 5'd1, 32'h11111111, 0, "b2b_ld0");
    runInstr(1, 1, 0, 0, 1, 0, 32'h0, 32'h14, 32'h0, 5'd2, 32'h22222222, 1, "b2b_ld1");
    runInstr(0, 0, 0, 0, 0, 1, 32'h0, 32'h18, 32'hA5A5A5A5, 5'd3, 32'h0, 0, "b2b_st");
    runInstr(1, 0, 0, 0, 0, 0, 32'h0, 32'h1C, 32'h0, 5'd4, 32'h0, 0, "b2b_alu");
    runInstr(1, 1, 0, 0, 1, 1, 32'h0, 32'h20, 32'h0, 5'd6, 32'h0, 0, "b2b_rdwr");
  endtask

  task test_random;
    logic mr, mw;
    logic [31:0] alu;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0: begin mr = 0; mw = 0; end
        1: begin mr = 1; mw = 0; end
        2: begin mr = 0; mw = 1; end
        default: begin mr = ($urandom_range(0, 3) == 0); mw = ~mr; mw = mw | ($urandom_range(0, 5) == 0); end
      endcase
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      runInstr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), mr, mw,
               $urandom, alu, $urandom, 5'($urandom), $urandom, $urandom_range(0, TO + 1), "random");
    end
  endtask

  task test_reset_mid;
    int seen;
    logic got;
    RegWrite = 1; MemtoReg = 1; MemRead = 1; MemWrite = 0; ALUResult = 32'h300; RegWriteAdd = 5'd12;
    seen = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (dmem_req) seen++;
      if (seen == 2) got = 1;
    end
    nVec++;
    if (!got) begin
      nErr++;
      $display("FAIL rstmid_wait: saw %0d req cycles want 2", seen);
    end
    rst = 1;
    #1;
    modelFault = 0;
    nVec++;
    if ({dmem_req, RegWrite_WB, MemtoReg_WB, mem_fault} !== 4'b0 ||
        ReadData_WB !== 0 || ALUResult_WB !== 0 || RegWriteAdd_WB !== 0) begin
      nErr++;
      $display("FAIL rstmid_async: req=%b rw=%b mtr=%b flt=%b rd=%h alu=%h ra=%0d want all 0",
               dmem_req, RegWrite_WB, MemtoReg_WB, mem_fault, ReadData_WB, ALUResult_WB, RegWriteAdd_WB);
    end
    @(posedge clk);
    @(negedge clk); clearInputs(); rst = 0;
    @(negedge clk); dmem_ack = 1; dmem_rdata = 32'hBADBAD00;
    @(posedge clk); #1; dmem_ack = 0;
    nVec++;
    if (dmem_req !== 0 || ReadData_WB !== 0 || RegWrite_WB !== 0 || mem_fault !== 0 || stall !== 0) begin
      nErr++;
      $display("FAIL rstmid_lateack: req=%b rd=%h rw=%b flt=%b stall=%b want 0 0 0 0 0",
               dmem_req, ReadData_WB, RegWrite_WB, mem_fault, stall);
    end
    runInstr(1, 1, 0, 0, 1, 0, 32'h0, 32'h104, 32'h0, 5'd8, 32'h0BADF00D, 1, "post_rst_load");
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_branch();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
